mem_access_stage: RTL and testbench

- MEM pipeline stage: sits between the EX/MEM register and the MEM/WB register.
- Performs loads and stores against a data memory over a req/ack handshake, with byte/half/word lane steering and sign/zero extension.
- Stalls the front of the pipeline while an access is outstanding.
- Feeds the MEM/WB register: load data, ALU result pass-through, destination register, WB controls.

---
 rtl/mem_access_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage between the EX/MEM and MEM/WB registers.
//               Performs loads and stores against a data memory over a
//               req/ack handshake. Handles byte/half/word lane steering and
//               sign/zero extension of loads. While an access is outstanding
//               it stalls the front of the pipeline.
// Optional    : MEM_TIMEOUT_EN - abort a BUSY access after TIMEOUT_CYCLES
//               cycles without an ack, suppress write-back and set err_o.
// Ports       : clk, rst_n          clock / async active-low reset
//               mem_read_i ..wb_i   EX/MEM register contents
//               mem_op_o..wb_o      to MEM/WB register (wb_o 00 = bubble)
//               stall_o             hold PC, IF/ID, ID/EX, EX/MEM
//               misalign_o          misaligned access dropped (1 cycle)
//               err_o               sticky timeout flag
//               dmem_*              data memory req/ack interface
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  wr_reg_i,
    input  logic [1:0]  wb_i,
    output logic [31:0] mem_op_o,
    output logic [31:0] result_o,
    output logic [4:0]  wr_reg_o,
    output logic [1:0]  wb_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        mem_op;
    logic        align_ok;
    logic        start;
    logic        ack_ok;
    logic        timeout_hit;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;

    // Latched copy of the access, held for the whole BUSY/DONE span
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic [4:0]  lat_wr_reg;
    logic [1:0]  lat_wb;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [31:0] cap_data;
    logic        req;

    assign mem_op = mem_read_i | mem_write_i;

    // Size 11 behaves as a word access
    always_comb begin
        align_ok = 1'b1;
        case (size_i)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~addr_i[0];
            default: align_ok = (addr_i[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        be_nx    = 4'b1111;
        wdata_nx = store_data_i;
        case (size_i)
            2'b00: begin
                be_nx    = 4'b0001 << addr_i[1:0];
                wdata_nx = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_nx    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{store_data_i[15:0]}};
            end
            default: begin
                be_nx    = 4'b1111;
                wdata_nx = store_data_i;
            end
        endcase
    end

    assign start  = (state == IDLE) && mem_op && align_ok;
    assign ack_ok = (state == BUSY) && dmem_ack_i;

    // Pull the addressed lane out of the read word and extend it
    function automatic logic [31:0] extract_load(
        input logic [31:0] rdata,
        input logic [1:0]  a,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            2'b00:   extract_load = {{24{b[7] & ~uns}}, b};
            2'b01:   extract_load = {{16{h[15] & ~uns}}, h};
            default: extract_load = rdata;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    logic [31:0] busy_cnt;
    logic        err;

    // Counter holds k-1 during the k-th BUSY cycle, so the abort edge
    // closes exactly TIMEOUT_CYCLES BUSY cycles.
    assign timeout_hit = (state == BUSY) && !dmem_ack_i &&
                         (busy_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 32'd0;
            err      <= 1'b0;
        end else begin
            if (start) begin
                busy_cnt <= 32'd0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + 32'd1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign err_o = err;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? BUSY : IDLE;
            BUSY:    state_nx = (ack_ok || timeout_hit) ? DONE : BUSY;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= 32'd0;
            lat_we     <= 1'b0;
            lat_be     <= 4'd0;
            lat_wdata  <= 32'd0;
            lat_wr_reg <= 5'd0;
            lat_wb     <= 2'd0;
            lat_size   <= 2'd0;
            lat_uns    <= 1'b0;
            cap_data   <= 32'd0;
            req        <= 1'b0;
        end else begin
            if (start) begin
                lat_addr   <= addr_i;
                lat_we     <= mem_write_i;
                lat_be     <= be_nx;
                lat_wdata  <= wdata_nx;
                lat_wr_reg <= wr_reg_i;
                lat_wb     <= wb_i;
                lat_size   <= size_i;
                lat_uns    <= unsigned_i;
                req        <= 1'b1;
            end else if (ack_ok) begin
                req      <= 1'b0;
                // A store (including read+write) returns no load data
                cap_data <= lat_we ? 32'd0
                          : extract_load(dmem_rdata_i, lat_addr[1:0], lat_size, lat_uns);
            end else if (timeout_hit) begin
                req      <= 1'b0;
                cap_data <= 32'd0;
                lat_wb   <= 2'b00;
            end
        end
    end

    assign dmem_req_o   = req;
    assign dmem_we_o    = lat_we;
    assign dmem_addr_o  = {lat_addr[31:2], 2'b00};
    assign dmem_be_o    = lat_be;
    assign dmem_wdata_o = lat_wdata;

    always_comb begin
        mem_op_o   = 32'd0;
        result_o   = addr_i;
        wr_reg_o   = wr_reg_i;
        wb_o       = wb_i;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    wb_o = 2'b00;
                    if (align_ok) begin
                        stall_o = 1'b1;
                    end else begin
                        misalign_o = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_o  = 1'b1;
                wb_o     = 2'b00;
                result_o = lat_addr;
                wr_reg_o = lat_wr_reg;
            end
            DONE: begin
                mem_op_o = cap_data;
                result_o = lat_addr;
                wr_reg_o = lat_wr_reg;
                wb_o     = lat_wb;
            end
            default: begin
                mem_op_o = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Table of IDLE-cycle
//               vectors plus directed multi-cycle access sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  wr_reg_i;
    logic [1:0]  wb_i;
    logic [31:0] mem_op_o;
    logic [31:0] result_o;
    logic [4:0]  wr_reg_o;
    logic [1:0]  wb_o;
    logic        stall_o;
    logic        misalign_o;
    logic        err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .wr_reg_i     (wr_reg_i),
        .wb_i         (wb_i),
        .mem_op_o     (mem_op_o),
        .result_o     (result_o),
        .wr_reg_o     (wr_reg_o),
        .wb_o         (wb_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .err_o        (err_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic [1:0]  e_wb;
        logic        e_stall;
        logic        e_mis;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        size_i       = 2'b00;
        unsigned_i   = 1'b0;
        addr_i       = 32'd0;
        store_data_i = 32'd0;
        wr_reg_i     = 5'd0;
        wb_i         = 2'b00;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] wreg,
                          input logic [1:0] wb);
        mem_read_i   = rd;
        mem_write_i  = wr;
        size_i       = sz;
        unsigned_i   = uns;
        addr_i       = addr;
        store_data_i = sd;
        wr_reg_i     = wreg;
        wb_i         = wb;
    endtask

    // Full access; ack arrives in BUSY cycle number 'delay' (>= 1)
    task automatic do_access(input string nm, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input logic [4:0] wreg, input logic [1:0] wb,
                             input int delay, input logic [31:0] rdata,
                             input logic [3:0] ebe, input logic [31:0] ewdata,
                             input logic [31:0] eop);
        int stalls;
        stalls = 0;
        @(negedge clk);
        set_op(rd, wr, sz, uns, addr, sd, wreg, wb);
        #1;
        chk({nm, " idle stall"}, 32'(stall_o), 32'd1);
        chk({nm, " idle wb"}, 32'(wb_o), 32'd0);
        if (stall_o) stalls++;
        @(posedge clk);
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            chk({nm, " busy req"}, 32'(dmem_req_o), 32'd1);
            chk({nm, " busy wb"}, 32'(wb_o), 32'd0);
            if (stall_o) stalls++;
            if (i == 1) begin
                chk({nm, " we"}, 32'(dmem_we_o), 32'(wr));
                chk({nm, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
                chk({nm, " be"}, 32'(dmem_be_o), 32'(ebe));
                chk({nm, " wdata"}, dmem_wdata_o, ewdata);
            end
            if (i == delay) begin
                dmem_ack_i   = 1'b1;
                dmem_rdata_i = rdata;
            end
            @(posedge clk);
            #1;
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = 32'd0;
        end
        @(negedge clk);
        chk({nm, " stall cycles"}, 32'(stalls), 32'(1 + delay));
        chk({nm, " done stall"}, 32'(stall_o), 32'd0);
        chk({nm, " done req"}, 32'(dmem_req_o), 32'd0);
        chk({nm, " done mem_op"}, mem_op_o, eop);
        chk({nm, " done result"}, result_o, addr);
        chk({nm, " done wr_reg"}, 32'(wr_reg_o), 32'(wreg));
        chk({nm, " done wb"}, 32'(wb_o), 32'(wb));
        clear_inputs();
        @(posedge clk);
        #1;
        chk({nm, " back idle stall"}, 32'(stall_o), 32'd0);
        chk({nm, " back idle mem_op"}, mem_op_o, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_1234,  5'd5, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 5'd31, 2'b11, 2'b11, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h0000_0301,  5'd3, 2'b01, 2'b00, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 32'h0000_0203,  5'd4, 2'b01, 2'b00, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 2'b10, 32'h0000_0302,  5'd0, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 32'h0000_0103,  5'd6, 2'b01, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 2'b01, 32'h0000_0202,  5'd0, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 32'h0000_0305,  5'd7, 2'b01, 2'b00, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 2'b11, 32'h0000_0300,  5'd7, 2'b01, 2'b00, 1'b1, 1'b0};

        rst_n        = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'd0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req", 32'(dmem_req_o), 32'd0);
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset mem_op", mem_op_o, 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset be", 32'(dmem_be_o), 32'd0);
        rst_n = 1'b1;

        // IDLE-cycle vectors, removed before the next clock edge
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            set_op(vecs[i].rd, vecs[i].wr, vecs[i].sz, 1'b0, vecs[i].addr,
                   32'h1111_2222, vecs[i].wreg, vecs[i].wb);
            #1;
            chk($sformatf("vec%0d result", i), result_o, vecs[i].addr);
            chk($sformatf("vec%0d wr_reg", i), 32'(wr_reg_o), 32'(vecs[i].wreg));
            chk($sformatf("vec%0d wb", i), 32'(wb_o), 32'(vecs[i].e_wb));
            chk($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d misalign", i), 32'(misalign_o), 32'(vecs[i].e_mis));
            chk($sformatf("vec%0d mem_op", i), mem_op_o, 32'd0);
            #1;
            clear_inputs();
        end

        // Misaligned access held over an edge issues no request
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'd0, 5'd3, 2'b01);
        @(posedge clk);
        #1;
        chk("misalign no req", 32'(dmem_req_o), 32'd0);
        chk("misalign no stall", 32'(stall_o), 32'd0);
        clear_inputs();

        // Ack outside BUSY is ignored
        @(negedge clk);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'd0;
        @(negedge clk);
        chk("idle ack stall", 32'(stall_o), 32'd0);
        chk("idle ack mem_op", mem_op_o, 32'd0);
        chk("idle ack req", 32'(dmem_req_o), 32'd0);

        do_access("lb signed", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 5'd9, 2'b01,
                  2, 32'h80FF_0000, 4'b1000, 32'd0, 32'hFFFF_FF80);
        do_access("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 5'd9, 2'b01,
                  1, 32'h80FF_0000, 4'b1000, 32'd0, 32'h0000_0080);
        do_access("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 2'b00,
                  1, 32'hDEAD_BEEF, 4'b1100, 32'hABCD_ABCD, 32'd0);
        do_access("lh signed", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0206, 32'd0, 5'd2, 2'b11,
                  1, 32'h8001_7FFF, 4'b1100, 32'h0000_0000, 32'hFFFF_8001);
        do_access("lhu low", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0204, 32'd0, 5'd2, 2'b11,
                  3, 32'h8001_F00F, 4'b0011, 32'h0000_0000, 32'h0000_F00F);
        do_access("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_565A, 5'd0, 2'b00,
                  1, 32'd0, 4'b0010, 32'h5A5A_5A5A, 32'd0);
        do_access("lw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0, 5'd12, 2'b01,
                  1, 32'h1234_5678, 4'b1111, 32'd0, 32'h1234_5678);
        do_access("rd+wr", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0600, 32'hCAFE_F00D, 5'd1, 2'b01,
                  1, 32'h1111_1111, 4'b1111, 32'hCAFE_F00D, 32'd0);

        // Reset in the middle of BUSY
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'd0, 5'd8, 2'b01);
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset req", 32'(dmem_req_o), 32'd1);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("mid reset req", 32'(dmem_req_o), 32'd0);
        chk("mid reset stall", 32'(stall_o), 32'd0);
        chk("mid reset result", result_o, 32'd0);
        chk("mid reset wb", 32'(wb_o), 32'd0);
        chk("mid reset mem_op", mem_op_o, 32'd0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'd0;
        @(negedge clk);
        chk("post reset stall", 32'(stall_o), 32'd0);
        chk("post reset req", 32'(dmem_req_o), 32'd0);
        chk("post reset mem_op", mem_op_o, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: the access aborts after 4 BUSY cycles
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0, 5'd7, 2'b01);
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dmem_req_o) n++;
            else break;
        end
        chk("timeout busy cycles", 32'(n), 32'd4);
        chk("timeout wb", 32'(wb_o), 32'd0);
        chk("timeout mem_op", mem_op_o, 32'd0);
        chk("timeout stall", 32'(stall_o), 32'd0);
        chk("timeout err", 32'(err_o), 32'd1);
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("err sticky", 32'(err_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("err cleared by reset", 32'(err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        // No ack: BUSY waits indefinitely, err stays 0
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0, 5'd7, 2'b01);
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req_o) n++;
        end
        chk("long busy req cycles", 32'(n), 32'd20);
        chk("long busy stall", 32'(stall_o), 32'd1);
        chk("long busy err", 32'(err_o), 32'd0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'd0;
        @(negedge clk);
        chk("late ack mem_op", mem_op_o, 32'h0BAD_F00D);
        chk("late ack wb", 32'(wb_o), 32'd1);
        clear_inputs();
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
